// File: rtl/ext_ram_banked.sv
// Banked LDPC message RAM: NUM_BANKS x ROW_DEPTH words, one write and one
// registered read per cycle, write-first bypass, and a hardware clear engine.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   chip_sel            gates wr_en/rd_en (the clear engine runs regardless)
//   clear               pulse: zero the whole array, one row of all banks per cycle
//   wr_en/addr/data     write port, address = {bank, row}
//   rd_en/addr          read port, address = {bank, row}
//   rd_data, rd_valid   registered read result and its one-cycle strobe
//   busy                clear engine active; all requests are rejected
module ext_ram_banked #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_BITS   = 6,
  parameter int NUM_BANKS  = 4,
  localparam int BANK_BITS  = $clog2(NUM_BANKS),
  localparam int ADDR_WIDTH = BANK_BITS + ROW_BITS,
  localparam int ROW_DEPTH  = 1 << ROW_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_sel,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ROW_BITS-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [BANK_BITS-1:0]  wr_bank, rd_bank;
  logic [ROW_BITS-1:0]   wr_row, rd_row;
  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

  assign busy     = (state_q == S_CLEAR);
  assign acc      = !busy && chip_sel;
  assign wr_acc   = acc && wr_en;
  assign rd_acc   = acc && rd_en;
  assign wr_bank  = wr_addr[ADDR_WIDTH-1:ROW_BITS];
  assign wr_row   = wr_addr[ROW_BITS-1:0];
  assign rd_bank  = rd_addr[ADDR_WIDTH-1:ROW_BITS];
  assign rd_row   = rd_addr[ROW_BITS-1:0];
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Storage is not reset; the clear engine zeroes it row by row, all
  // banks in parallel. User writes cannot collide with it since busy
  // rejects every request.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [ROW_DEPTH];
    logic                  we;

    assign we         = wr_acc && (wr_bank == BANK_BITS'(b));
    assign bank_rd[b] = mem_q[rd_row];

    always_ff @(posedge clk) begin
      if (busy) begin
        mem_q[cnt_q] <= '0;
      end else if (we) begin
        mem_q[wr_row] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ROW_BITS'(1);
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Write-first: a same-cycle write to the read address wins over the
  // array contents, which only update at this same edge.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (rd_acc) begin
      rd_valid_d = 1'b1;
      if (wr_acc && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = bank_rd[rd_bank];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_ext_ram_banked.sv
// Bench for ext_ram_banked: directed scenarios plus random traffic,
// checked each cycle against a word-array reference model.
module tb_ext_ram_banked;

  localparam int DEPTH = 64;
  localparam int N     = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chip_sel = 1'b0;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  ext_ram_banked dut (
    .clk      (clk),
    .rst      (rst),
    .chip_sel (chip_sel),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] ref_mem [N];
  int         m_left;
  logic [7:0] m_rd;
  logic       m_v;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic zero_ref();
    for (int i = 0; i < N; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    chip_sel = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    m_left = DEPTH;
    m_rd = 8'h00;
    zero_ref();
    chk("rst_busy", busy, 1);
    chk("rst_vld", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    repeat (cyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic cs, input logic clr,
                      input logic we, input logic [7:0] wa,
                      input logic [7:0] wd, input logic re,
                      input logic [7:0] ra);
    logic acc;
    chip_sel = cs; clear = clr;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    acc = (m_left == 0) && cs;
    m_v = acc && re;
    if (m_v) m_rd = (we && wa == ra) ? wd : ref_mem[ra];
    if (acc && we) ref_mem[wa] = wd;
    @(posedge clk);
    #1;
    if (clr) begin
      m_left = DEPTH;
      zero_ref();
    end else if (m_left > 0) begin
      m_left--;
    end
    chk("rd_valid", rd_valid, m_v);
    chk("rd_data", rd_data, m_rd);
    chk("busy", busy, m_left > 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1, 0, 0, 0, 0, 1, a);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1, 0, 1, a, d, 0, 0);
  endtask

  initial begin
    do_reset(3);

    // power-up clear, then whole array reads zero
    idle(DEPTH);
    chk("clr_done", busy, 0);
    for (int a = 0; a < N; a++) rd(8'(a));

    // bank 0 / bank 1 writes and reads
    wr(8'h00, 8'h4B);
    wr(8'h40, 8'h0D);
    rd(8'h00);
    chk("rd00", rd_data, 8'h4B);
    rd(8'h40);
    chk("rd40", rd_data, 8'h0D);
    idle(1);

    // same-cycle write-first bypass
    step(1, 0, 1, 8'h00, 8'h18, 1, 8'h00);
    chk("byp", rd_data, 8'h18);
    rd(8'h00);

    // chip_sel low blocks both ports
    step(0, 0, 1, 8'h05, 8'hFF, 1, 8'h05);
    chk("cs0_vld", rd_valid, 0);
    rd(8'h05);
    chk("cs1_rd05", rd_data, 8'h00);

    // fill, clear, reads during busy rejected, then all zero
    for (int a = 0; a < N; a++) wr(8'(a), 8'hA5);
    rd(8'hC3);
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 1, 8'(i), 8'h77, 1, 8'(i * 4));
    end
    chk("clr2_done", busy, 0);
    for (int a = 0; a < N; a++) rd(8'(a));

    // clear restarted by a second pulse while busy
    step(1, 1, 0, 0, 0, 0, 0);
    idle(20);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(DEPTH);

    // reset mid-clear restarts the full clear
    step(1, 1, 0, 0, 0, 0, 0);
    idle(10);
    do_reset(2);
    idle(DEPTH);
    chk("rst_clr_done", busy, 0);

    // random traffic with address collisions and rare clears
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] wa, ra;
      wa = 8'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom);
      step($urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0,
           1'($urandom), wa, 8'($urandom), 1'($urandom), ra);
    end
    idle(DEPTH);
    for (int a = 0; a < N; a++) rd(8'(a));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
